pc_sequencer: RTL and testbench

//  Owns the fetch PC of the 5-stage pipeline; replaces the bare PC register + adder pair.

---
 rtl/pc_sequencer_pkg.sv | 15 +
 rtl/pc_next_select.sv | 33 +++
 rtl/pc_sequencer.sv | 106 ++++++++++
 tb/tb_pc_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: FSM state encoding and default parameters.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_HALT_DRAIN = 2'd1,
        ST_HALTED     = 2'd2
    } state_e;

    localparam int          DEF_XLEN         = 32;
    localparam int unsigned DEF_RESET_PC     = 0;
    localparam int unsigned DEF_PC_STEP      = 4;
    localparam int unsigned DEF_DRAIN_CYCLES = 3;

endpackage

// File: rtl/pc_next_select.sv
// Combinational next-PC priority mux: halt/drain freeze, redirect, stall hold, sequential step.
module pc_next_select
    import pc_sequencer_pkg::*;
#(
    parameter int          XLEN    = DEF_XLEN,
    parameter int unsigned PC_STEP = DEF_PC_STEP
) (
    input  state_e            i_state,
    input  logic [XLEN-1:0]   i_current_pc,
    input  logic              i_stall,
    input  logic              i_redirect_valid,
    input  logic [XLEN-1:0]   i_redirect_target,
    output logic [XLEN-1:0]   o_next_pc
);

    logic [XLEN-1:0] w_target_aligned;

    // Redirect targets are forced word-aligned; the low two bits are dropped.
    assign w_target_aligned = i_redirect_target & ~XLEN'(3);

    always_comb begin
        // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
        o_next_pc = i_current_pc + XLEN'(PC_STEP);
        if (i_state != ST_RUN) begin
            o_next_pc = i_current_pc;
        end else if (i_redirect_valid) begin
            o_next_pc = w_target_aligned;
        end else if (i_stall) begin
            o_next_pc = i_current_pc;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner for the 5-stage pipeline: PC register, halt/drain FSM, cycle counter and
// IF/ID, ID/EX flush decode.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN         = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC     = XLEN'(DEF_RESET_PC),
    parameter int unsigned     PC_STEP      = DEF_PC_STEP,
    parameter int unsigned     DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_target,
    input  logic              halt_in_id,
    output logic [XLEN-1:0]   current_pc,
    output logic [XLEN-1:0]   next_pc,
    output logic              ifid_write_en,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              is_halted,
    output logic [31:0]       cycle_count
);

    state_e          r_state;
    logic [3:0]      r_drain_cnt;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_cycle_count;
    logic            r_is_halted;
    logic [XLEN-1:0] w_next_pc;
    logic            w_halt_accept;

    pc_next_select #(
        .XLEN    (XLEN),
        .PC_STEP (PC_STEP)
    ) u_next_select (
        .i_state           (r_state),
        .i_current_pc      (r_pc),
        .i_stall           (stall),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .o_next_pc         (w_next_pc)
    );

    // A halt seen alongside a redirect is wrong-path; alongside a stall it waits.
    assign w_halt_accept = (r_state == ST_RUN) && halt_in_id && !stall && !redirect_valid;

    always_comb begin
        ifid_write_en = 1'b1;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        if (r_state != ST_RUN) begin
            ifid_write_en = 1'b0;
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
        end else if (redirect_valid) begin
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
        end else if (stall) begin
            ifid_write_en = 1'b0;
            flush_id_ex   = 1'b1;
        end else if (halt_in_id) begin
            flush_if_id   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_drain_cnt   <= '0;
            r_pc          <= RESET_PC;
            r_cycle_count <= '0;
            r_is_halted   <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (r_state != ST_HALTED) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_halt_accept) begin
                        r_state     <= ST_HALT_DRAIN;
                        r_drain_cnt <= 4'(DRAIN_CYCLES - 1);
                    end
                end
                ST_HALT_DRAIN: begin
                    if (r_drain_cnt == 4'd0) begin
                        r_state     <= ST_HALTED;
                        r_is_halted <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign current_pc  = r_pc;
    assign next_pc     = w_next_pc;
    assign is_halted   = r_is_halted;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against
// an abstract run/drain/halted reference model.
module tb_pc_sequencer;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_PC     = 32'h0;
    localparam int unsigned PC_STEP      = 4;
    localparam int unsigned DRAIN_CYCLES = 3;

    localparam int PH_RUN    = 0;
    localparam int PH_DRAIN  = 1;
    localparam int PH_HALTED = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_in_id;
    logic [31:0] current_pc;
    logic [31:0] next_pc;
    logic        ifid_write_en;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        is_halted;
    logic [31:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_cycles;
    int          m_phase;
    int          m_drain_left;
    logic        m_halted;

    typedef struct packed {
        logic [31:0] npc;
        logic        wen;
        logic        fif;
        logic        fie;
    } exp_t;

    always #5 clk = ~clk;

    pc_sequencer #(
        .XLEN         (XLEN),
        .RESET_PC     (RESET_PC),
        .PC_STEP      (PC_STEP),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_in_id      (halt_in_id),
        .current_pc      (current_pc),
        .next_pc         (next_pc),
        .ifid_write_en   (ifid_write_en),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .is_halted       (is_halted),
        .cycle_count     (cycle_count)
    );

    function automatic exp_t expect_comb();
        exp_t e;
        e.npc = m_pc + PC_STEP;
        e.wen = 1'b1;
        e.fif = 1'b0;
        e.fie = 1'b0;
        if (m_phase != PH_RUN) begin
            e.npc = m_pc;
            e.wen = 1'b0;
            e.fif = 1'b1;
            e.fie = 1'b1;
        end else if (redirect_valid) begin
            e.npc = (redirect_target / 4) * 4;
            e.fif = 1'b1;
            e.fie = 1'b1;
        end else if (stall) begin
            e.npc = m_pc;
            e.wen = 1'b0;
            e.fie = 1'b1;
        end else begin
            e.fif = halt_in_id;
        end
        return e;
    endfunction

    // Drive inputs mid-cycle and let combinational outputs settle.
    task automatic apply(input logic rst, input logic s, input logic r,
                         input logic [31:0] t, input logic h);
        @(negedge clk);
        reset           = rst;
        stall           = s;
        redirect_valid  = r;
        redirect_target = t;
        halt_in_id      = h;
        #1;
    endtask

    // Advance across the rising edge, stepping the model with the inputs held there.
    task automatic commit();
        exp_t e;
        e = expect_comb();
        @(posedge clk);
        if (reset) begin
            m_pc         = RESET_PC;
            m_cycles     = 32'd0;
            m_phase      = PH_RUN;
            m_drain_left = 0;
            m_halted     = 1'b0;
        end else begin
            if (m_phase != PH_HALTED) m_cycles = m_cycles + 32'd1;
            m_pc = e.npc;
            if (m_phase == PH_RUN && halt_in_id && !stall && !redirect_valid) begin
                m_phase      = PH_DRAIN;
                m_drain_left = DRAIN_CYCLES;
            end else if (m_phase == PH_DRAIN) begin
                m_drain_left = m_drain_left - 1;
                if (m_drain_left == 0) begin
                    m_phase  = PH_HALTED;
                    m_halted = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        commit();
    endtask

    task automatic run_free(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            commit();
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            n_checks++;
            if (current_pc !== 32'(i * 4)) begin
                n_fail++;
                $display("FAIL reset_run pc[%0d]: got %h want %h", i, current_pc, 32'(i * 4));
            end
            n_checks++;
            if ({flush_if_id, flush_id_ex, ifid_write_en} !== 3'b001) begin
                n_fail++;
                $display("FAIL reset_run ctl[%0d]: got %b want 001", i, {flush_if_id, flush_id_ex, ifid_write_en});
            end
            if (i == 0) begin
                n_checks++;
                if (cycle_count !== 32'd0 || is_halted !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_state: cycle_count %0d is_halted %b want 0 0", cycle_count, is_halted);
                end
            end
            commit();
        end
    endtask

    task automatic test_stall();
        do_reset();
        run_free(2);
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            n_checks++;
            if (current_pc !== 32'h8 || next_pc !== 32'h8) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: pc %h next %h want 8 8", i, current_pc, next_pc);
            end
            n_checks++;
            if ({ifid_write_en, flush_id_ex, flush_if_id} !== 3'b010) begin
                n_fail++;
                $display("FAIL stall_ctl[%0d]: wen/fie/fif %b want 010", i, {ifid_write_en, flush_id_ex, flush_if_id});
            end
            commit();
        end
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        commit();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (current_pc !== 32'hC) begin
            n_fail++;
            $display("FAIL stall_resume: pc %h want c", current_pc);
        end
        commit();
    endtask

    task automatic test_redirect();
        do_reset();
        run_free(8);
        apply(1'b0, 1'b1, 1'b1, 32'h103, 1'b0);
        n_checks++;
        if (current_pc !== 32'h20 || next_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL redirect_next: pc %h next %h want 20 100", current_pc, next_pc);
        end
        n_checks++;
        if ({flush_if_id, flush_id_ex, ifid_write_en} !== 3'b111) begin
            n_fail++;
            $display("FAIL redirect_ctl: fif/fie/wen %b want 111", {flush_if_id, flush_id_ex, ifid_write_en});
        end
        commit();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (current_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL redirect_land: pc %h want 100", current_pc);
        end
        commit();
    endtask

    task automatic test_halt();
        do_reset();
        run_free(15);
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        n_checks++;
        if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b0 || next_pc !== 32'h40) begin
            n_fail++;
            $display("FAIL halt_accept: fif %b fie %b next %h want 1 0 40", flush_if_id, flush_id_ex, next_pc);
        end
        commit();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            n_checks++;
            if ({is_halted, ifid_write_en, flush_if_id, flush_id_ex} !== 4'b0011 || current_pc !== 32'h40) begin
                n_fail++;
                $display("FAIL halt_drain[%0d]: halted/wen/fif/fie %b pc %h want 0011 40", i,
                         {is_halted, ifid_write_en, flush_if_id, flush_id_ex}, current_pc);
            end
            commit();
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            n_checks++;
            if (is_halted !== 1'b1 || current_pc !== 32'h40 || cycle_count !== 32'd19) begin
                n_fail++;
                $display("FAIL halted[%0d]: halted %b pc %h cycles %0d want 1 40 19", i, is_halted, current_pc, cycle_count);
            end
            commit();
        end
    endtask

    task automatic test_halt_qualify();
        do_reset();
        run_free(3);
        apply(1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
        n_checks++;
        if (next_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL halt_redirect_next: next %h want 200", next_pc);
        end
        commit();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (current_pc !== 32'h200 || next_pc !== 32'h204 || ifid_write_en !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_redirect_run: pc %h next %h wen %b want 200 204 1", current_pc, next_pc, ifid_write_en);
        end
        commit();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            n_checks++;
            if (next_pc !== 32'h204 || flush_if_id !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_stall_defer[%0d]: next %h fif %b want 204 0", i, next_pc, flush_if_id);
            end
            commit();
        end
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        commit();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (current_pc !== 32'h208 || next_pc !== 32'h208 || ifid_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_after_stall: pc %h next %h wen %b want 208 208 0", current_pc, next_pc, ifid_write_en);
        end
        commit();
        do_reset();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (current_pc !== RESET_PC || is_halted !== 1'b0 || cycle_count !== 32'd0 || ifid_write_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_drain: pc %h halted %b cycles %0d wen %b want 0 0 0 1",
                     current_pc, is_halted, cycle_count, ifid_write_en);
        end
        commit();
    endtask

    task automatic test_wrap();
        apply(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        commit();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (current_pc !== 32'hFFFF_FFFC || next_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap: pc %h next %h want fffffffc 0", current_pc, next_pc);
        end
        commit();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (current_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_land: pc %h want 0", current_pc);
        end
        commit();
    endtask

    task automatic test_random();
        exp_t e;
        logic rst, s, r, h;
        logic [31:0] t;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = (m_phase == PH_HALTED) ? ($urandom_range(3) == 0) : ($urandom_range(149) == 0);
            s   = ($urandom_range(3) == 0);
            r   = (m_phase == PH_RUN) && ($urandom_range(5) == 0);
            h   = ($urandom_range(11) == 0);
            t   = $urandom;
            apply(rst, s, r, t, h);
            e = expect_comb();
            n_checks++;
            if (current_pc !== m_pc || cycle_count !== m_cycles || is_halted !== m_halted) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: pc %h cyc %0d halted %b want %h %0d %b",
                         i, current_pc, cycle_count, is_halted, m_pc, m_cycles, m_halted);
            end
            if (!rst) begin
                n_checks++;
                if (next_pc !== e.npc || {ifid_write_en, flush_if_id, flush_id_ex} !== {e.wen, e.fif, e.fie}) begin
                    n_fail++;
                    $display("FAIL rand_comb[%0d]: next %h wen/fif/fie %b want %h %b", i, next_pc,
                             {ifid_write_en, flush_if_id, flush_id_ex}, e.npc, {e.wen, e.fif, e.fie});
                end
            end
            commit();
        end
    endtask

    initial begin
        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        halt_in_id      = 1'b0;
        m_pc            = RESET_PC;
        m_cycles        = 32'd0;
        m_phase         = PH_RUN;
        m_drain_left    = 0;
        m_halted        = 1'b0;
        test_reset();
        test_stall();
        test_redirect();
        test_halt();
        test_halt_qualify();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
